// File: rtl/twofish_host_if.sv
// ---------------------------------------------------------------------------
// twofish_host_if
//
// Word-serial host front-end for the Twofish datapath core. Collects 32-bit
// key/block words from a valid/ready input stream (most-significant word
// first), assembles the 128-bit key/block operands, pulses Start, follows
// busy through to completion and returns the 128-bit result as four 32-bit
// words on a valid/ready output stream. A timeout aborts a transaction whose
// core never completes; err then stays set until the next first beat.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   in_valid/in_ready   input word handshake
//   in_data [31:0]      key/block word, MSW first
//   in_ende             first beat only: 0 = encrypt, 1 = decrypt
//   in_key_keep         first beat only: 1 = reuse stored key, 4 block words
//   out_valid/out_ready result word handshake
//   out_data [31:0]     result word, MSW first
//   out_last            high with the 4th result word
//   err                 sticky timeout flag
//   block/key [127:0]   core operands
//   EnDe, Start         core direction, single-cycle start pulse
//   addr [7:0]          core address, tied to zero
//   o [127:0], busy     core result and busy
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// LOAD_KEY | idle; first beat picks direction/key reuse, key words 0..3
// LOAD_BLK | block words 0..3
// START    | Start pulse is high, timeout counter restarts
// WAIT_HI  | waiting for core busy to rise
// WAIT_LO  | waiting for core busy to fall, then capture o
// OUT      | presenting result words 0..3
module twofish_host_if #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_ende,
    input  logic         in_key_keep,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         err,
    output logic [127:0] block,
    output logic [127:0] key,
    output logic         EnDe,
    output logic         Start,
    output logic [7:0]   addr,
    input  logic [127:0] o,
    input  logic         busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_BLK,
        START,
        WAIT_HI,
        WAIT_LO,
        OUT
    } state_t;

    state_t         state;
    logic [1:0]     idx;
    logic [CW-1:0]  cnt;
    logic [127:0]   result;
    logic           in_hs;
    logic           timed_out;

    assign addr      = 8'h00;
    assign in_hs     = in_valid && in_ready;
    assign timed_out = (cnt == CW'(TIMEOUT_CYCLES - 1));

    function automatic logic [127:0] put_word(input logic [127:0] v,
                                              input logic [1:0]   i,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = v;
        case (i)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] v,
                                             input logic [1:0]   i);
        logic [31:0] w;
        case (i)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= LOAD_KEY;
            idx       <= 2'd0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            Start     <= 1'b0;
            EnDe      <= 1'b0;
            key       <= '0;
            block     <= '0;
            result    <= '0;
        end else begin
            Start <= 1'b0;
            case (state)
                LOAD_KEY: begin
                    if (in_hs) begin
                        if (idx == 2'd0) begin
                            EnDe <= in_ende;
                            err  <= 1'b0;
                        end
                        if (idx == 2'd0 && in_key_keep) begin
                            block <= put_word(block, 2'd0, in_data);
                            idx   <= 2'd1;
                            state <= LOAD_BLK;
                        end else begin
                            key <= put_word(key, idx, in_data);
                            // idx wraps 3 -> 0, which is where block loading starts
                            idx <= idx + 2'd1;
                            if (idx == 2'd3)
                                state <= LOAD_BLK;
                        end
                    end
                end

                LOAD_BLK: begin
                    if (in_hs) begin
                        block <= put_word(block, idx, in_data);
                        idx   <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            in_ready <= 1'b0;
                            Start    <= 1'b1;
                            state    <= START;
                        end
                    end
                end

                START: begin
                    // The Start cycle itself counts as the first elapsed cycle,
                    // so the abort lands TIMEOUT_CYCLES cycles after Start.
                    cnt   <= CW'(1);
                    state <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (timed_out) begin
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        idx      <= 2'd0;
                        state    <= LOAD_KEY;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (busy)
                            state <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    // A completion seen in the timeout cycle still wins.
                    if (!busy) begin
                        result    <= o;
                        out_data  <= o[127:96];
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        idx       <= 2'd0;
                        state     <= OUT;
                    end else if (timed_out) begin
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        idx      <= 2'd0;
                        state    <= LOAD_KEY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        if (idx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            idx       <= 2'd0;
                            state     <= LOAD_KEY;
                        end else begin
                            out_data <= get_word(result, idx + 2'd1);
                            out_last <= (idx == 2'd2);
                            idx      <= idx + 2'd1;
                        end
                    end
                end

                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    idx       <= 2'd0;
                    state     <= LOAD_KEY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_twofish_host_if.sv
module tb_twofish_host_if;

    localparam logic [127:0] KAT_CT = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_ende;
    logic         in_key_keep;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         err;
    logic [127:0] block;
    logic [127:0] key;
    logic         EnDe;
    logic         Start;
    logic [7:0]   addr;
    logic [127:0] o;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    bit rnd_rdy = 1'b0;
    bit stuck = 1'b0;

    logic [32:0] exp_q[$];

    always #5 Clk = ~Clk;

    twofish_host_if #(.TIMEOUT_CYCLES(64)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ende(in_ende), .in_key_keep(in_key_keep),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err),
        .block(block), .key(key), .EnDe(EnDe), .Start(Start), .addr(addr),
        .o(o), .busy(busy)
    );

    // Stand-in core: an invertible keyed mapping that gives the published
    // zero-key/zero-block answer, with a latency of about a dozen cycles.
    function automatic logic [127:0] core_enc(input logic [127:0] k, input logic [127:0] b);
        return {b[119:0], b[127:120]} ^ k ^ KAT_CT;
    endfunction

    function automatic logic [127:0] core_dec(input logic [127:0] k, input logic [127:0] c);
        logic [127:0] x;
        x = c ^ k ^ KAT_CT;
        return {x[7:0], x[127:8]};
    endfunction

    int core_cnt = 0;
    always @(posedge Clk) begin
        if (Reset) begin
            core_cnt <= 0;
            busy     <= 1'b0;
        end else if (Start && !stuck) begin
            o        <= EnDe ? core_dec(key, block) : core_enc(key, block);
            core_cnt <= 12;
            busy     <= 1'b0;
        end else if (core_cnt > 0) begin
            busy     <= (core_cnt >= 3 && core_cnt <= 10);
            core_cnt <= core_cnt - 1;
        end
    end

    initial o = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wd(input logic [127:0] v, input int i);
        return v[127-32*i -: 32];
    endfunction

    // Scoreboard monitor: pops on every accepted output word, and checks
    // that a stalled word does not change.
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge Clk) begin
        logic [32:0] e;
        if (Start) start_cnt++;
        if (out_valid && prev_stall) begin
            chk("stall_data", 128'(out_data), 128'(prev_data));
            chk("stall_last", 128'(out_last), 128'(prev_last));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 128'(out_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 128'(out_data), 128'(e[31:0]));
                chk("out_last", 128'(out_last), 128'(e[32]));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    always @(posedge Clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 99) < 30);
        end
    end

    task automatic push_res(input logic [127:0] r, input int nwords);
        for (int i = 0; i < nwords; i++)
            exp_q.push_back({(i == 3), wd(r, i)});
    endtask

    task automatic send_beat(input logic [31:0] d, input logic e, input logic k, input bit gappy);
        int n;
        if (gappy) begin
            while ($urandom_range(0, 99) >= 30) begin
                in_valid = 1'b0;
                @(posedge Clk);
                #1;
            end
        end
        in_data     = d;
        in_ende     = e;
        in_key_keep = k;
        in_valid    = 1'b1;
        n = 0;
        @(posedge Clk);
        while (!in_ready && n < 300) begin
            n++;
            @(posedge Clk);
        end
        if (n >= 300) chk("in_ready_timeout", 128'(in_ready), 128'(1));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [127:0] k, input logic [127:0] b,
                        input logic e, input logic keep, input bit gappy);
        if (!keep)
            for (int i = 0; i < 4; i++) send_beat(wd(k, i), e, 1'b0, gappy);
        for (int i = 0; i < 4; i++) send_beat(wd(b, i), e, keep, gappy);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            n++;
            @(posedge Clk);
        end
        #1;
        chk("drain_remaining", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_out_last"},  128'(out_last),  128'(0));
        chk({tag, "_out_data"},  128'(out_data),  128'(0));
        chk({tag, "_err"},       128'(err),       128'(0));
        chk({tag, "_start"},     128'(Start),     128'(0));
        chk({tag, "_ende"},      128'(EnDe),      128'(0));
        chk({tag, "_key"},       key,             128'(0));
        chk({tag, "_block"},     block,           128'(0));
        chk({tag, "_addr"},      128'(addr),      128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rb, ct;
        int s0, n;

        Reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ende = 1'b0;
        in_key_keep = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk_reset_vals("por");
        Reset = 1'b0;

        // Encrypt known answer
        s0 = start_cnt;
        load('0, '0, 1'b0, 1'b0, 1'b0);
        push_res(KAT_CT, 4);
        drain();
        chk("kat_start_pulses", 128'(start_cnt - s0), 128'(1));

        // Round trip with key reuse
        s0 = start_cnt;
        load('0, KAT_CT, 1'b1, 1'b1, 1'b0);
        push_res('0, 4);
        drain();
        chk("rt_key_kept", key, 128'(0));
        chk("rt_ende", 128'(EnDe), 128'(1));
        chk("rt_start_pulses", 128'(start_cnt - s0), 128'(1));

        // Backpressure and gaps
        rnd_rdy = 1'b1;
        rk = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        ct = core_enc(rk, rb);
        load(rk, rb, 1'b0, 1'b0, 1'b1);
        push_res(ct, 4);
        drain();
        chk("gap_key", key, rk);
        load(rk, ct, 1'b1, 1'b1, 1'b1);
        push_res(rb, 4);
        drain();
        rnd_rdy = 1'b0;
        @(posedge Clk);
        #2;
        out_ready = 1'b1;

        // Timeout with a core that never goes busy
        stuck = 1'b1;
        load('0, '0, 1'b0, 1'b0, 1'b0);
        n = 0;
        @(negedge Clk);
        while (!Start && n < 10) begin
            n++;
            @(negedge Clk);
        end
        chk("to_start_seen", 128'(Start), 128'(1));
        for (int k = 1; k <= 66; k++) begin
            @(negedge Clk);
            if (k == 63) chk("to_err_before", 128'(err), 128'(0));
            if (k == 64) chk("to_err_at64", 128'(err), 128'(1));
            if (k == 65) chk("to_in_ready", 128'(in_ready), 128'(1));
        end
        chk("to_err_sticky", 128'(err), 128'(1));
        stuck = 1'b0;
        send_beat(32'h0, 1'b0, 1'b0, 1'b0);
        chk("to_err_cleared", 128'(err), 128'(0));

        // Reset after 5 input beats
        rk = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) send_beat(wd(rk, i), 1'b1, 1'b0, 1'b0);
        send_beat(32'hA5A5_5A5A, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk_reset_vals("rst_in");
        Reset = 1'b0;

        // Reset after output word 1
        out_ready = 1'b0;
        load('0, '0, 1'b0, 1'b0, 1'b0);
        push_res(KAT_CT, 2);
        n = 0;
        @(negedge Clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge Clk);
        end
        chk("rst_out_valid_seen", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk_reset_vals("rst_out");
        chk("rst_out_popped", 128'(exp_q.size()), 128'(0));
        Reset = 1'b0;
        out_ready = 1'b1;

        // Fresh known answer after reset
        load('0, '0, 1'b0, 1'b0, 1'b0);
        push_res(KAT_CT, 4);
        drain();

        repeat (3) @(posedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/twofish_host_if.md
# twofish_host_if

Word-serial host front-end that drives the Twofish `datapath` core as its initiator. It accepts 32-bit key and block words over a valid/ready input stream and assembles them into the core's 128-bit `key`/`block` operands. It pulses `Start`, tracks `busy` through to completion, then returns the 128-bit result `o` as four 32-bit words over a valid/ready output stream. It sits between the bus/host logic and `datapath` and replaces hand-driven `Start`/`block`/`key` sequencing.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles from the `Start` pulse to `busy` falling before the transaction is aborted.

- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when high together with `in_valid`.
- `in_data`  in  32  key/block word, most-significant word first.
- `in_ende`  in  1  sampled on the first beat of a transaction: 0 = encrypt, 1 = decrypt.
- `in_key_keep`  in  1  sampled on the first beat: 1 = reuse the stored key, so only 4 block words follow.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  downstream accepts the result word.
- `out_data`  out  32  result word, most-significant word first.
- `out_last`  out  1  high with the 4th result word.
- `err`  out  1  sticky timeout flag; cleared by `Reset` or by the first beat of the next transaction.
- `block`  out  128  core plaintext/ciphertext operand.
- `key`  out  128  core key operand.
- `EnDe`  out  1  core direction.
- `Start`  out  1  single-cycle core start pulse.
- `addr`  out  8  core address; tied to 8'h00.
- `o`  in  128  core result.
- `busy`  in  1  core busy.

## Operation
- States: `LOAD_KEY`, `LOAD_BLK`, `START`, `WAIT_HI`, `WAIT_LO`, `OUT`. A 2-bit word index and a timeout counter sized for `TIMEOUT_CYCLES` accompany the state machine.
- **LOAD_KEY** (idle state): `in_ready`=1.
  - The first accepted beat latches `EnDe`←`in_ende` and clears `err`.
  - If `in_key_keep`=1, that beat is block word 0 and the machine goes to `LOAD_BLK` with index=1.
  - Otherwise it is key word 0. Key words 0..3 load `key[127:96]`, `[95:64]`, `[63:32]`, `[31:0]`. After word 3 the machine goes to `LOAD_BLK` with index=0.
- **LOAD_BLK**: `in_ready`=1. Block words 0..3 load `block` in the same MSW-first order. After word 3 the machine goes to `START`.
- **START**: `Start`=1 for exactly one cycle, timeout counter cleared, then → `WAIT_HI`.
- **WAIT_HI**: `busy`=1 → `WAIT_LO`.
- **WAIT_LO**: `busy`=0 → capture `o` into the result register, then → `OUT`.
- Timeout: the counter increments every cycle in `WAIT_HI`/`WAIT_LO`. When it reaches `TIMEOUT_CYCLES`, the block sets `err`=1, discards the result and returns to `LOAD_KEY`. No output words are produced.
- **OUT**: `out_valid`=1 and `out_data` = result word[index], MSW first. The index advances on `out_valid && out_ready`; `out_last`=1 at index 3. After word 3 is accepted → `LOAD_KEY`.
- `in_ready`=0 in `START`, `WAIT_HI`, `WAIT_LO` and `OUT`. There is no overlap of the next load with the current output.
- `key`, `block` and `EnDe` are registers. They change only on accepted input beats, so they are stable from `Start` until `busy` falls.
- The stored key persists across transactions. `in_key_keep`=1 right after reset therefore uses key 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_data`=0, `err`=0, `Start`=0, `EnDe`=0, `key`=0, `block`=0, `addr`=0. State = `LOAD_KEY`, index=0, counter=0.
- A reset in any state, including mid-load or mid-output, returns the block to the reset values on the next edge. Partial words and any pending result are dropped.
- `Start` is high in the cycle after the edge that accepts the last block word.
- `WAIT_HI` tolerates `busy` rising 1 or more cycles after `Start`.
- `out_valid` rises in the cycle after the edge at which `busy`=0 is sampled in `WAIT_LO`.
- `out_data`/`out_last` hold stable while `out_valid`=1 and `out_ready`=0.
- Throughput: 8 (or 4) input cycles + 1 + core latency + 1 + 4 output cycles, with no stalls.
- Gaps in `in_valid` or `out_ready` only stall; they never change data or order.

## Test plan
- **Encrypt, known answer**: key=0, block=0 (8 beats, `in_ende`=0), with the real `datapath` -> exactly one `Start` pulse; output words 9F589F5C, F6122C32, B6BFEC2F, 2AE8C35A with `out_last` on the 4th.
- **Round trip with key reuse**: feed the above ciphertext as 4 block words with `in_key_keep`=1, `in_ende`=1 -> output 4 words all 00000000; `key` unchanged at 0.
- **Backpressure and gaps**: random `in_valid` and `out_ready` duty at 30%, random key and block, encrypt then decrypt -> decrypted output equals the original block; `out_data` stable while stalled.
- **Timeout**: stub core with `busy` stuck at 0 -> `err`=1 exactly 64 cycles after `Start`, no `out_valid`, `in_ready`=1 the next cycle. The next first beat clears `err`.
- **Reset mid-operation**: assert `Reset` after 5 input beats, and separately after output word 1 -> next cycle all outputs equal reset values. A fresh zero-key/zero-block encrypt afterwards yields 9F589F5C....
